// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the CPU sequencer: decoder state codes, opcodes and the strobe bundle.
// State and opcode values are defined only here and imported wherever they are needed.
package cpu_sequencer_pkg;

  localparam logic [3:0] STATE_FETCH_PC   = 4'd0;
  localparam logic [3:0] STATE_FETCH_INST = 4'd1;
  localparam logic [3:0] STATE_LOAD_ADDR  = 4'd2;
  localparam logic [3:0] STATE_SKIP_JUMP  = 4'd3;
  localparam logic [3:0] STATE_JUMP       = 4'd4;
  localparam logic [3:0] STATE_RAM_A      = 4'd5;
  localparam logic [3:0] STATE_STORE_A    = 4'd6;
  localparam logic [3:0] STATE_RAM_B      = 4'd7;
  localparam logic [3:0] STATE_OUT_A      = 4'd8;
  localparam logic [3:0] STATE_ADD        = 4'd9;
  localparam logic [3:0] STATE_SUB        = 4'd10;
  localparam logic [3:0] STATE_HALT       = 4'd11;
  localparam logic [3:0] STATE_NEXT       = 4'd12;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Last legal micro-cycle; reaching it without NEXT is an overrun.
  localparam logic [3:0] CYCLE_MAX = 4'd7;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic a_out;
    logic a_load;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic display_load;
  } strobes_t;

endpackage

// File: rtl/cpu_strobe_decode.sv
// Combinational control-strobe decode from the decoder state; everything is quiet while halted
// or for an unknown state code.
module cpu_strobe_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0] state,
  input  logic       halted,
  output strobes_t   strobes
);

  always_comb begin
    strobes = '0;
    if (!halted) begin
      case (state)
        STATE_FETCH_PC: begin
          strobes.pc_out   = 1'b1;
          strobes.mar_load = 1'b1;
        end
        STATE_FETCH_INST: begin
          strobes.ram_out = 1'b1;
          strobes.ir_load = 1'b1;
          strobes.pc_inc  = 1'b1;
        end
        STATE_LOAD_ADDR: begin
          strobes.ram_out  = 1'b1;
          strobes.mar_load = 1'b1;
          strobes.pc_inc   = 1'b1;
        end
        STATE_SKIP_JUMP: strobes.pc_inc = 1'b1;
        STATE_JUMP: begin
          strobes.ram_out = 1'b1;
          strobes.pc_load = 1'b1;
        end
        STATE_RAM_A: begin
          strobes.ram_out = 1'b1;
          strobes.a_load  = 1'b1;
        end
        STATE_STORE_A: begin
          strobes.a_out    = 1'b1;
          strobes.ram_load = 1'b1;
        end
        STATE_RAM_B: begin
          strobes.ram_out = 1'b1;
          strobes.b_load  = 1'b1;
        end
        STATE_OUT_A: begin
          strobes.a_out        = 1'b1;
          strobes.display_load = 1'b1;
        end
        STATE_ADD: begin
          strobes.alu_out = 1'b1;
          strobes.a_load  = 1'b1;
        end
        STATE_SUB: begin
          strobes.alu_out = 1'b1;
          strobes.a_load  = 1'b1;
          strobes.alu_sub = 1'b1;
        end
        default: strobes = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Micro-cycle counter, opcode/zero-flag latches and halt/overrun tracking for the CPU,
// with the control strobes decoded by cpu_strobe_decode.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] state,
  input  logic [7:0] bus,
  input  logic       alu_zero,
  input  logic       cont,
  output logic [3:0] cycle,
  output logic [3:0] opcode,
  output logic       eq_zero,
  output logic       halted,
  output logic       seq_err,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_load,
  output logic       ir_load,
  output logic       a_out,
  output logic       a_load,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       display_load
);

  logic [3:0] cycle_q, cycle_d;
  logic [3:0] opcode_q, opcode_d;
  logic       eq_zero_q, eq_zero_d;
  logic       halted_q, halted_d;
  logic       seq_err_q, seq_err_d;
  strobes_t   strobes;

  // Only the opcode nibble of the bus matters here.
  logic unused_bus;
  assign unused_bus = ^bus[3:0];

  always_comb begin
    cycle_d   = cycle_q;
    opcode_d  = opcode_q;
    eq_zero_d = eq_zero_q;
    halted_d  = halted_q;
    seq_err_d = seq_err_q;
    if (halted_q) begin
      if (cont) begin
        halted_d = 1'b0;
        cycle_d  = '0;
      end
    end else begin
      if (state == STATE_NEXT) begin
        cycle_d = '0;
      end else begin
        if (state == STATE_HALT) begin
          halted_d = 1'b1;
        end else begin
          cycle_d = cycle_q + 4'd1;
        end
        // Overrun wraps the counter even on HALT so it never leaves 0..7.
        if (cycle_q == CYCLE_MAX) begin
          cycle_d   = '0;
          seq_err_d = 1'b1;
        end
      end
      if (state == STATE_FETCH_INST) opcode_d = bus[7:4];
      if (state == STATE_ADD || state == STATE_SUB) eq_zero_d = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q   <= '0;
      opcode_q  <= '0;
      eq_zero_q <= 1'b0;
      halted_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      opcode_q  <= opcode_d;
      eq_zero_q <= eq_zero_d;
      halted_q  <= halted_d;
      seq_err_q <= seq_err_d;
    end
  end

  cpu_strobe_decode u_strobe_decode (
    .state   (state),
    .halted  (halted_q),
    .strobes (strobes)
  );

  assign cycle        = cycle_q;
  assign opcode       = opcode_q;
  assign eq_zero      = eq_zero_q;
  assign halted       = halted_q;
  assign seq_err      = seq_err_q;
  assign pc_out       = strobes.pc_out;
  assign pc_inc       = strobes.pc_inc;
  assign pc_load      = strobes.pc_load;
  assign mar_load     = strobes.mar_load;
  assign ram_out      = strobes.ram_out;
  assign ram_load     = strobes.ram_load;
  assign ir_load      = strobes.ir_load;
  assign a_out        = strobes.a_out;
  assign a_load       = strobes.a_load;
  assign b_load       = strobes.b_load;
  assign alu_out      = strobes.alu_out;
  assign alu_sub      = strobes.alu_sub;
  assign display_load = strobes.display_load;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 state  input  4  control state from the decoder, encodings from the shared parameters file.
REQ-004 bus  input  8  data bus; bits [7:4] carry the opcode during instruction fetch.
REQ-005 alu_zero  input  1  ALU result equals zero, valid during ADD/SUB states.
REQ-006 cont  input  1  resume pulse; honoured only while halted.
REQ-007 cycle  output  4  current micro-cycle index fed back to the decoder.
REQ-008 opcode  output  4  latched instruction opcode fed back to the decoder.
REQ-009 eq_zero  output  1  registered zero flag fed back to the decoder.
REQ-010 halted  output  1  CPU stopped.
REQ-011 seq_err  output  1  sticky flag: cycle overran without a NEXT state.
REQ-012 Strobes, output, 1 bit each: pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, a_out, a_load, b_load, alu_out, alu_sub, display_load.

Function
REQ-013 Strobes SHALL be a combinational decode of state, all forced to 0 while halted=1.
REQ-014 FETCH_PC: pc_out, mar_load. FETCH_INST: ram_out, ir_load, pc_inc. LOAD_ADDR: ram_out, mar_load, pc_inc. SKIP_JUMP: pc_inc. JUMP: ram_out, pc_load.
REQ-015 RAM_A: ram_out, a_load. STORE_A: a_out, ram_load. RAM_B: ram_out, b_load. OUT_A: a_out, display_load. ADD: alu_out, a_load. SUB: alu_out, a_load, alu_sub. HALT, NEXT: no strobes.
REQ-016 Cycle counter, when not halted: state=NEXT -> 0 next edge; state=HALT -> halted set, cycle holds; otherwise cycle+1.
REQ-017 If cycle=7 and state is not NEXT, cycle SHALL return to 0 on the next edge and seq_err SHALL set (sticky until reset).
REQ-018 opcode SHALL load bus[7:4] on the edge ending FETCH_INST; otherwise it holds.
REQ-019 eq_zero SHALL load alu_zero on the edge ending ADD or SUB; otherwise it holds.
REQ-020 While halted: cycle, opcode and eq_zero hold; cont=1 clears halted and sets cycle to 0 on the same edge.
REQ-021 cont while not halted SHALL be ignored.
REQ-022 Latency: the effect of state on cycle, opcode and eq_zero appears exactly one edge later; strobes follow state in the same cycle.
REQ-023 An undefined state code SHALL produce no strobes and advance cycle as in REQ-016.

Reset
REQ-024 reset_n=0 SHALL immediately force cycle=0, opcode=0, eq_zero=0, halted=0, seq_err=0, independent of clk.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction; the first cycle after release is cycle 0.

Structure
REQ-026 STATE_* and OP_* encodings SHALL live only in the shared parameters file and be included, never redefined.
REQ-027 The strobe decode SHALL be one sub-module, cpu_strobe_decode (state, halted -> strobes); counter and flags SHALL be in cpu_sequencer.

Verification
REQ-028 Reset, then state=FETCH_PC, FETCH_INST with bus=0x3A, then NEXT -> cycle goes 0,1,2,0; opcode=0x3; ir_load and pc_inc high only during FETCH_INST.
REQ-029 state=SUB with alu_zero=1, then ADD with alu_zero=0 -> eq_zero=1 after the first edge and 0 after the second; alu_sub high only in SUB.
REQ-030 state=HALT at cycle 2 -> halted=1, cycle holds at 2 and all strobes are 0 for 10 clocks; cont pulse -> halted=0, cycle=0.
REQ-031 state held at RAM_A for 9 edges from cycle 0 -> cycle wraps 7 to 0; seq_err=1 and stays 1.
REQ-032 reset_n dropped between edges at cycle 4 with halted=1 -> all outputs reset immediately, without waiting for an edge.
REQ-033 cont=1 while not halted at cycle 3 -> cycle advances to 4; halted stays 0.
